// File: rtl/usb_bus_initiator.sv
// Initiator for the 8-bit multiplexed USB register bus: turns command/stream
// requests into an address-latch phase followed by timed read/write strobe beats.
module usb_bus_initiator #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ALE_CYC    = 2,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                  clk_usb,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic [ADDR_WIDTH-1:0] usb_addr_o,
  output logic [DATA_WIDTH-1:0] usb_d_o,
  output logic                  usb_d_oe,
  input  logic [DATA_WIDTH-1:0] usb_d_i,
  output logic                  usb_cen_o,
  output logic                  usb_alen_o,
  output logic                  usb_rdn_o,
  output logic                  usb_wrn_o
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W-1:0]        beats_q, beats_d;
  logic                    is_wr_q, is_wr_d;
  logic                    held_q, held_d;
  logic                    beat_start;

  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   d_o_d;
  logic                    oe_d;
  logic [DATA_WIDTH-1:0]   rsp_data_d;
  logic                    rsp_valid_d;
  logic                    rsp_last_d;
  logic                    wr_ready_d;
  logic                    cmd_ready_d;
  logic                    cen_d;
  logic                    alen_d;
  logic                    rdn_d;
  logic                    wrn_d;

  // State and every bus/handshake output are registered here.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beats_q    <= '0;
      is_wr_q    <= 1'b0;
      held_q     <= 1'b0;
      usb_addr_o <= '0;
      usb_d_o    <= '0;
      usb_d_oe   <= 1'b0;
      rsp_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_last   <= 1'b0;
      wr_ready   <= 1'b0;
      cmd_ready  <= 1'b1;
      usb_cen_o  <= 1'b1;
      usb_alen_o <= 1'b1;
      usb_rdn_o  <= 1'b1;
      usb_wrn_o  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      is_wr_q    <= is_wr_d;
      held_q     <= held_d;
      usb_addr_o <= addr_d;
      usb_d_o    <= d_o_d;
      usb_d_oe   <= oe_d;
      rsp_data   <= rsp_data_d;
      rsp_valid  <= rsp_valid_d;
      rsp_last   <= rsp_last_d;
      wr_ready   <= wr_ready_d;
      cmd_ready  <= cmd_ready_d;
      usb_cen_o  <= cen_d;
      usb_alen_o <= alen_d;
      usb_rdn_o  <= rdn_d;
      usb_wrn_o  <= wrn_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    is_wr_d     = is_wr_q;
    held_d      = held_q;
    addr_d      = usb_addr_o;
    d_o_d       = usb_d_o;
    oe_d        = usb_d_oe;
    rsp_data_d  = rsp_data;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    wr_ready_d  = 1'b0;
    beat_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        oe_d = 1'b0;
        if (cmd_valid && cmd_ready) begin
          state_d = ST_ALE;
          cnt_d   = '0;
          is_wr_d = cmd_write;
          addr_d  = cmd_addr;
          beats_d = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
        end
      end
      ST_ALE: begin
        if (cnt_q == CNT_W'(ALE_CYC - 1)) begin
          state_d    = ST_SETUP;
          cnt_d      = '0;
          beat_start = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETUP: begin
        if (!held_q) begin
          // Write stalled for data: setup count only starts once data is on the bus.
          if (wr_valid) begin
            d_o_d      = wr_data;
            oe_d       = 1'b1;
            wr_ready_d = 1'b1;
            held_d     = 1'b1;
          end
        end else if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          if (!is_wr_q) begin
            rsp_data_d  = usb_d_i;
            rsp_valid_d = 1'b1;
            rsp_last_d  = (beats_q == LEN_W'(1));
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d = '0;
          if (beats_q > LEN_W'(1)) begin
            beats_d    = beats_q - LEN_W'(1);
            state_d    = ST_SETUP;
            beat_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering SETUP for a new beat: grab write data now if it is already offered.
    if (beat_start) begin
      held_d = !is_wr_q;
      if (is_wr_q && wr_valid) begin
        d_o_d      = wr_data;
        oe_d       = 1'b1;
        wr_ready_d = 1'b1;
        held_d     = 1'b1;
      end
    end

    cmd_ready_d = (state_d == ST_IDLE);
    cen_d       = (state_d == ST_IDLE);
    alen_d      = (state_d != ST_ALE);
    wrn_d       = !((state_d == ST_STROBE) && is_wr_d);
    rdn_d       = !((state_d == ST_STROBE) && !is_wr_d);
  end

endmodule

// File: tb/tb_usb_bus_initiator.sv
// Self-checking bench for usb_bus_initiator: bus monitor, write-data source,
// read responder and per-scenario tasks with expected-value scoreboards.
module tb_usb_bus_initiator;

  logic        clk_usb = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [15:0] cmd_len = 16'h0000;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic [7:0]  usb_addr_o;
  logic [7:0]  usb_d_o;
  logic        usb_d_oe;
  logic [7:0]  usb_d_i;
  logic        usb_cen_o, usb_alen_o, usb_rdn_o, usb_wrn_o;

  usb_bus_initiator dut (
    .clk_usb(clk_usb), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .usb_addr_o(usb_addr_o), .usb_d_o(usb_d_o), .usb_d_oe(usb_d_oe), .usb_d_i(usb_d_i),
    .usb_cen_o(usb_cen_o), .usb_alen_o(usb_alen_o), .usb_rdn_o(usb_rdn_o), .usb_wrn_o(usb_wrn_o)
  );

  always #5 clk_usb = ~clk_usb;

  int total = 0;
  int bad = 0;

  // Monitor-owned observations (written only by the monitor).
  int alen_falls = 0, rdn_pulses = 0, rdn_low_cyc = 0, wrn_pulses = 0;
  int oe_hi_cyc = 0, wr_ready_cnt = 0, rsp_cnt = 0, viol_cnt = 0;
  int hi_run = 0, last_gap = 0;
  logic p_alen = 1'b1, p_rdn = 1'b1, p_wrn = 1'b1, p_oe = 1'b0, p_cen = 1'b1;
  logic [7:0] alen_addr[$];
  logic [7:0] obs_wr_addr[$], obs_wr_data[$];
  logic       obs_wr_oe[$];
  logic [7:0] obs_rsp_data[$];
  logic       obs_rsp_last[$];

  // Stimulus-owned data (written only by the test tasks).
  logic [7:0] wr_arr[256];
  logic [7:0] rd_arr[256];
  int wr_avail = 0;
  logic [7:0] exp_wr_addr[$], exp_wr_data[$];
  logic [7:0] exp_rsp_data[$];
  logic       exp_rsp_last[$];
  int wr_ptr = 0, rsp_ptr = 0;

  // Write source offers the next queued byte until it sees wr_ready; responder
  // presents the byte belonging to the current read strobe.
  assign wr_valid = (wr_ready_cnt < wr_avail);
  assign wr_data  = wr_arr[8'(wr_ready_cnt)];
  assign usb_d_i  = rd_arr[8'(rdn_pulses - 1)];

  always @(negedge clk_usb) begin
    if (!usb_alen_o && p_alen) begin
      alen_falls++;
      alen_addr.push_back(usb_addr_o);
    end
    if (!usb_rdn_o && p_rdn) rdn_pulses++;
    if (!usb_rdn_o) rdn_low_cyc++;
    if (!usb_wrn_o && p_wrn) begin
      wrn_pulses++;
      obs_wr_addr.push_back(usb_addr_o);
      obs_wr_data.push_back(usb_d_o);
      obs_wr_oe.push_back(usb_d_oe);
    end
    if (usb_d_oe) oe_hi_cyc++;
    if (wr_ready) wr_ready_cnt++;
    if (rsp_valid) begin
      rsp_cnt++;
      obs_rsp_data.push_back(rsp_data);
      obs_rsp_last.push_back(rsp_last);
    end
    if (!usb_rdn_o && !usb_wrn_o) viol_cnt++;
    if (!usb_alen_o && (!usb_rdn_o || !usb_wrn_o)) viol_cnt++;
    if (!usb_wrn_o && !p_wrn && (usb_d_oe != p_oe)) viol_cnt++;
    if (usb_cen_o) hi_run++;
    else if (p_cen) begin
      last_gap = hi_run;
      hi_run = 0;
    end
    p_alen = usb_alen_o; p_rdn = usb_rdn_o; p_wrn = usb_wrn_o;
    p_oe = usb_d_oe; p_cen = usb_cen_o;
  end

  task automatic step;
    @(negedge clk_usb);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [15:0] len);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      step;
      n++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
    step;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~a; cmd_len = 16'hBEEF;
  endtask

  task automatic wait_idle;
    int n = 0;
    step;
    while (!cmd_ready && n < 500) begin
      step;
      n++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL idle_timeout: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    step;
    total++;
    if ({cmd_ready, usb_cen_o, usb_alen_o, usb_rdn_o, usb_wrn_o} !== 5'b11111) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 11111",
               {cmd_ready, usb_cen_o, usb_alen_o, usb_rdn_o, usb_wrn_o});
    end
    total++;
    if ({usb_d_oe, rsp_valid, rsp_last, wr_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b required 0000", {usb_d_oe, rsp_valid, rsp_last, wr_ready});
    end
    total++;
    if ({usb_addr_o, usb_d_o, rsp_data} !== 24'h0) begin
      bad++;
      $display("FAIL reset_buses: got %h required 000000", {usb_addr_o, usb_d_o, rsp_data});
    end
    step;
    reset_n = 1'b1;
    step;
  endtask

  task automatic test_single_write;
    int s_alen = alen_falls;
    logic e_alen, e_wrn, e_rdy;
    wr_arr[8'(wr_avail)] = 8'h5C; wr_avail++;
    exp_wr_addr.push_back(8'h2A); exp_wr_data.push_back(8'h5C);
    step;
    issue(1'b1, 8'h2A, 16'd1);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) step;
      e_alen = !(k == 1 || k == 2);
      e_wrn  = !(k >= 5 && k <= 7);
      e_rdy  = (k == 9);
      total++;
      if ({usb_alen_o, usb_wrn_o, usb_rdn_o, cmd_ready, usb_cen_o} !== {e_alen, e_wrn, 1'b1, e_rdy, e_rdy}) begin
        bad++;
        $display("FAIL single_write_ctrl cycle %0d: alen/wrn/rdn/rdy/cen=%b required %b", k,
                 {usb_alen_o, usb_wrn_o, usb_rdn_o, cmd_ready, usb_cen_o}, {e_alen, e_wrn, 1'b1, e_rdy, e_rdy});
      end
      if (k <= 2) begin
        total++;
        if (usb_addr_o !== 8'h2A) begin
          bad++;
          $display("FAIL single_write_addr cycle %0d: got %h required 2a", k, usb_addr_o);
        end
      end
      if (k >= 5 && k <= 7) begin
        total++;
        if ({usb_d_oe, usb_d_o} !== {1'b1, 8'h5C}) begin
          bad++;
          $display("FAIL single_write_data cycle %0d: oe/data=%b/%h required 1/5c", k, usb_d_oe, usb_d_o);
        end
      end
    end
    total++;
    if (alen_falls - s_alen != 1) begin
      bad++;
      $display("FAIL single_write_ale: got %0d ALE phases required 1", alen_falls - s_alen);
    end
    while (exp_wr_addr.size() > 0) begin
      total++;
      if (wr_ptr >= obs_wr_addr.size()) begin
        bad++;
        $display("FAIL single_write_sb: missing beat, required %h@%h", exp_wr_data[0], exp_wr_addr[0]);
      end else if ({obs_wr_addr[wr_ptr], obs_wr_data[wr_ptr], obs_wr_oe[wr_ptr]} !==
                   {exp_wr_addr[0], exp_wr_data[0], 1'b1}) begin
        bad++;
        $display("FAIL single_write_sb: got %h@%h oe=%b required %h@%h oe=1", obs_wr_data[wr_ptr],
                 obs_wr_addr[wr_ptr], obs_wr_oe[wr_ptr], exp_wr_data[0], exp_wr_addr[0]);
      end
      wr_ptr++;
      void'(exp_wr_addr.pop_front()); void'(exp_wr_data.pop_front());
    end
  endtask

  task automatic test_single_read;
    int s_rdn = rdn_pulses, s_low = rdn_low_cyc, s_oe = oe_hi_cyc;
    rd_arr[8'(rdn_pulses)] = 8'hA5;
    exp_rsp_data.push_back(8'hA5); exp_rsp_last.push_back(1'b1);
    issue(1'b0, 8'h10, 16'd1);
    wait_idle;
    total++;
    if ({rdn_pulses - s_rdn, rdn_low_cyc - s_low, oe_hi_cyc - s_oe} !== {32'd1, 32'd3, 32'd0}) begin
      bad++;
      $display("FAIL single_read_bus: rdn pulses/low cycles/oe cycles=%0d/%0d/%0d required 1/3/0",
               rdn_pulses - s_rdn, rdn_low_cyc - s_low, oe_hi_cyc - s_oe);
    end
    while (exp_rsp_data.size() > 0) begin
      total++;
      if (rsp_ptr >= obs_rsp_data.size()) begin
        bad++;
        $display("FAIL single_read_sb: missing response, required %h", exp_rsp_data[0]);
      end else if ({obs_rsp_data[rsp_ptr], obs_rsp_last[rsp_ptr]} !== {exp_rsp_data[0], exp_rsp_last[0]}) begin
        bad++;
        $display("FAIL single_read_sb: got %h last=%b required %h last=%b", obs_rsp_data[rsp_ptr],
                 obs_rsp_last[rsp_ptr], exp_rsp_data[0], exp_rsp_last[0]);
      end
      rsp_ptr++;
      void'(exp_rsp_data.pop_front()); void'(exp_rsp_last.pop_front());
    end
  endtask

  task automatic test_read_burst;
    int s_alen = alen_falls, s_rdn = rdn_pulses, s_rsp = rsp_cnt;
    for (int i = 0; i < 4; i++) begin
      rd_arr[8'(rdn_pulses + i)] = 8'(i + 1);
      exp_rsp_data.push_back(8'(i + 1));
      exp_rsp_last.push_back(i == 3);
    end
    issue(1'b0, 8'h40, 16'd4);
    wait_idle;
    total++;
    if ({alen_falls - s_alen, rdn_pulses - s_rdn, rsp_cnt - s_rsp} !== {32'd1, 32'd4, 32'd4}) begin
      bad++;
      $display("FAIL read_burst_counts: ale/rdn/rsp=%0d/%0d/%0d required 1/4/4",
               alen_falls - s_alen, rdn_pulses - s_rdn, rsp_cnt - s_rsp);
    end
    while (exp_rsp_data.size() > 0) begin
      total++;
      if (rsp_ptr >= obs_rsp_data.size()) begin
        bad++;
        $display("FAIL read_burst_sb: missing response, required %h", exp_rsp_data[0]);
      end else if ({obs_rsp_data[rsp_ptr], obs_rsp_last[rsp_ptr]} !== {exp_rsp_data[0], exp_rsp_last[0]}) begin
        bad++;
        $display("FAIL read_burst_sb: got %h last=%b required %h last=%b", obs_rsp_data[rsp_ptr],
                 obs_rsp_last[rsp_ptr], exp_rsp_data[0], exp_rsp_last[0]);
      end
      rsp_ptr++;
      void'(exp_rsp_data.pop_front()); void'(exp_rsp_last.pop_front());
    end
  endtask

  task automatic test_write_stall;
    int s_alen = alen_falls, s_wrn = wrn_pulses, s_rdy = wr_ready_cnt, n = 0;
    for (int i = 0; i < 3; i++) begin
      exp_wr_addr.push_back(8'h33);
      exp_wr_data.push_back(8'(8'hC1 + i));
    end
    wr_arr[8'(wr_avail)] = 8'hC1; wr_avail++;
    step;
    issue(1'b1, 8'h33, 16'd3);
    while (wr_ready_cnt == s_rdy && n < 50) begin
      step;
      n++;
    end
    total++;
    if (wr_ready_cnt == s_rdy) begin
      bad++;
      $display("FAIL write_stall_first_ready: wr_ready count=%0d required %0d", wr_ready_cnt, s_rdy + 1);
    end
    repeat (5) step;
    for (int k = 0; k < 5; k++) begin
      step;
      total++;
      if ({usb_cen_o, usb_wrn_o, wr_ready} !== 3'b010) begin
        bad++;
        $display("FAIL write_stall_hold cycle %0d: cen/wrn/wr_ready=%b required 010", k,
                 {usb_cen_o, usb_wrn_o, wr_ready});
      end
    end
    wr_arr[8'(wr_avail)] = 8'hC2; wr_arr[8'(wr_avail + 1)] = 8'hC3; wr_avail += 2;
    wait_idle;
    total++;
    if ({alen_falls - s_alen, wrn_pulses - s_wrn, wr_ready_cnt - s_rdy} !== {32'd1, 32'd3, 32'd3}) begin
      bad++;
      $display("FAIL write_stall_counts: ale/wrn/wr_ready=%0d/%0d/%0d required 1/3/3",
               alen_falls - s_alen, wrn_pulses - s_wrn, wr_ready_cnt - s_rdy);
    end
    while (exp_wr_addr.size() > 0) begin
      total++;
      if (wr_ptr >= obs_wr_addr.size()) begin
        bad++;
        $display("FAIL write_stall_sb: missing beat, required %h@%h", exp_wr_data[0], exp_wr_addr[0]);
      end else if ({obs_wr_addr[wr_ptr], obs_wr_data[wr_ptr], obs_wr_oe[wr_ptr]} !==
                   {exp_wr_addr[0], exp_wr_data[0], 1'b1}) begin
        bad++;
        $display("FAIL write_stall_sb: got %h@%h oe=%b required %h@%h oe=1", obs_wr_data[wr_ptr],
                 obs_wr_addr[wr_ptr], obs_wr_oe[wr_ptr], exp_wr_data[0], exp_wr_addr[0]);
      end
      wr_ptr++;
      void'(exp_wr_addr.pop_front()); void'(exp_wr_data.pop_front());
    end
  endtask

  task automatic test_reset_mid_strobe;
    int n = 0, s_rsp;
    wr_arr[8'(wr_avail)] = 8'h77; wr_avail++;
    step;
    issue(1'b1, 8'h44, 16'd1);
    while (usb_wrn_o && n < 50) begin
      step;
      n++;
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({usb_wrn_o, usb_d_oe, usb_cen_o, cmd_ready} !== 4'b1011) begin
      bad++;
      $display("FAIL reset_mid_strobe: wrn/oe/cen/rdy=%b required 1011",
               {usb_wrn_o, usb_d_oe, usb_cen_o, cmd_ready});
    end
    step;
    step;
    reset_n = 1'b1;
    wr_ptr = obs_wr_addr.size();
    s_rsp = rsp_cnt;
    rd_arr[8'(rdn_pulses)] = 8'h3C;
    exp_rsp_data.push_back(8'h3C); exp_rsp_last.push_back(1'b1);
    step;
    issue(1'b0, 8'h55, 16'd1);
    wait_idle;
    total++;
    if (rsp_cnt - s_rsp != 1) begin
      bad++;
      $display("FAIL reset_recover_rsp_count: got %0d required 1", rsp_cnt - s_rsp);
    end
    while (exp_rsp_data.size() > 0) begin
      total++;
      if (rsp_ptr >= obs_rsp_data.size()) begin
        bad++;
        $display("FAIL reset_recover_sb: missing response, required %h", exp_rsp_data[0]);
      end else if ({obs_rsp_data[rsp_ptr], obs_rsp_last[rsp_ptr]} !== {exp_rsp_data[0], exp_rsp_last[0]}) begin
        bad++;
        $display("FAIL reset_recover_sb: got %h last=%b required %h last=%b", obs_rsp_data[rsp_ptr],
                 obs_rsp_last[rsp_ptr], exp_rsp_data[0], exp_rsp_last[0]);
      end
      rsp_ptr++;
      void'(exp_rsp_data.pop_front()); void'(exp_rsp_last.pop_front());
    end
  endtask

  task automatic test_back_to_back;
    int s_alen = alen_falls, s_rdn = rdn_pulses, s_idx = alen_addr.size();
    rd_arr[8'(rdn_pulses)] = 8'h5A;
    exp_rsp_data.push_back(8'h5A); exp_rsp_last.push_back(1'b1);
    wr_arr[8'(wr_avail)] = 8'h99; wr_avail++;
    step;
    issue(1'b0, 8'h20, 16'd0);
    issue(1'b1, 8'h21, 16'd1);
    wait_idle;
    total++;
    if ({alen_falls - s_alen, rdn_pulses - s_rdn, last_gap} !== {32'd2, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL back_to_back_counts: ale/rdn/cen_gap=%0d/%0d/%0d required 2/1/1",
               alen_falls - s_alen, rdn_pulses - s_rdn, last_gap);
    end
    total++;
    if (alen_addr.size() < s_idx + 2) begin
      bad++;
      $display("FAIL back_to_back_addr: %0d ALE phases seen required 2", alen_addr.size() - s_idx);
    end else if ({alen_addr[s_idx], alen_addr[s_idx + 1]} !== 16'h2021) begin
      bad++;
      $display("FAIL back_to_back_addr: got %h,%h required 20,21", alen_addr[s_idx], alen_addr[s_idx + 1]);
    end
    while (exp_rsp_data.size() > 0) begin
      total++;
      if (rsp_ptr >= obs_rsp_data.size()) begin
        bad++;
        $display("FAIL back_to_back_sb: missing response, required %h", exp_rsp_data[0]);
      end else if ({obs_rsp_data[rsp_ptr], obs_rsp_last[rsp_ptr]} !== {exp_rsp_data[0], exp_rsp_last[0]}) begin
        bad++;
        $display("FAIL back_to_back_sb: got %h last=%b required %h last=%b", obs_rsp_data[rsp_ptr],
                 obs_rsp_last[rsp_ptr], exp_rsp_data[0], exp_rsp_last[0]);
      end
      rsp_ptr++;
      void'(exp_rsp_data.pop_front()); void'(exp_rsp_last.pop_front());
    end
    total++;
    if (obs_rsp_data.size() != rsp_ptr) begin
      bad++;
      $display("FAIL rsp_extra: got %0d responses required %0d", obs_rsp_data.size(), rsp_ptr);
    end
    total++;
    if (viol_cnt != 0) begin
      bad++;
      $display("FAIL bus_rules: got %0d strobe/ALE/oe rule breaks required 0", viol_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      wr_arr[i] = 8'h00;
      rd_arr[i] = 8'h00;
    end
    test_reset;
    test_single_write;
    test_single_read;
    test_read_burst;
    test_write_stall;
    test_reset_mid_strobe;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
